// File: rtl/mux_rr_reg_if.sv
// Handshake bundle between upstream channels, the registered mux and the downstream sink.
// Signal names keep the block's i_/o_ direction, seen from the mux.
interface mux_rr_reg_if #(
    parameter int WIDTH = 5,
    parameter int NCH   = 4,
    parameter int SELW  = 2
);
    logic [NCH*WIDTH-1:0] i_data;
    logic [NCH-1:0]       i_valid;
    logic [NCH-1:0]       o_ready;
    logic                 i_mode;
    logic [SELW-1:0]      i_sel;
    logic [WIDTH-1:0]     o_data;
    logic [SELW-1:0]      o_chan;
    logic                 o_valid;
    logic                 i_ready;

    modport slave (
        input  i_data, i_valid, i_mode, i_sel, i_ready,
        output o_ready, o_data, o_chan, o_valid
    );

    modport master (
        output i_data, i_valid, i_mode, i_sel, i_ready,
        input  o_ready, o_data, o_chan, o_valid
    );
endinterface

// File: rtl/mux_rr_reg.sv
// Registered N-channel mux with a fixed-select or round-robin grant and a one-word output stage.
// Grants are issued only when the output register can load, so every grant is a transfer.
module mux_rr_reg #(
    parameter int WIDTH = 5,
    parameter int NCH   = 4,
    parameter int SELW  = 2
) (
    input  logic          i_clk,
    input  logic          i_rst,
    mux_rr_reg_if.slave   bus
);

    logic [WIDTH-1:0] ch_data [NCH];

    logic [SELW-1:0]  ptr_q, ptr_d;
    logic [WIDTH-1:0] o_data_q, o_data_d;
    logic [SELW-1:0]  o_chan_q, o_chan_d;
    logic             o_valid_q, o_valid_d;

    logic             load;
    logic             fix_req;
    logic             hi_found, lo_found;
    logic [SELW-1:0]  hi_idx, lo_idx;
    logic             req_any;
    logic             gnt_any;
    logic [SELW-1:0]  gnt_idx;
    logic [WIDTH-1:0] gnt_data;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
            assign ch_data[gi]     = bus.i_data[gi*WIDTH +: WIDTH];
            assign bus.o_ready[gi] = gnt_any && (int'(gnt_idx) == gi);
        end
    endgenerate

    assign load = !o_valid_q || bus.i_ready;

    // Round-robin search split in two passes: channels at/above ptr first, then the wrapped ones below.
    always_comb begin
        fix_req  = 1'b0;
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int k = 0; k < NCH; k++) begin
            if (k == int'(bus.i_sel)) begin
                fix_req = bus.i_valid[k];
            end
            if (!hi_found && bus.i_valid[k] && (k >= int'(ptr_q))) begin
                hi_found = 1'b1;
                hi_idx   = k[SELW-1:0];
            end
            if (!lo_found && bus.i_valid[k] && (k < int'(ptr_q))) begin
                lo_found = 1'b1;
                lo_idx   = k[SELW-1:0];
            end
        end
    end

    always_comb begin
        if (bus.i_mode) begin
            req_any = hi_found || lo_found;
            gnt_idx = hi_found ? hi_idx : lo_idx;
        end else begin
            req_any = fix_req;
            gnt_idx = bus.i_sel;
        end
        gnt_any = req_any && load && !i_rst;
    end

    always_comb begin
        gnt_data = '0;
        for (int k = 0; k < NCH; k++) begin
            if (k == int'(gnt_idx)) begin
                gnt_data = ch_data[k];
            end
        end
    end

    always_comb begin
        ptr_d     = ptr_q;
        o_data_d  = o_data_q;
        o_chan_d  = o_chan_q;
        o_valid_d = o_valid_q;
        if (load) begin
            o_valid_d = gnt_any;
            if (gnt_any) begin
                o_data_d = gnt_data;
                o_chan_d = gnt_idx;
                if (bus.i_mode) begin
                    ptr_d = (int'(gnt_idx) == NCH - 1) ? '0 : gnt_idx + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ptr_q     <= '0;
            o_data_q  <= '0;
            o_chan_q  <= '0;
            o_valid_q <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            o_data_q  <= o_data_d;
            o_chan_q  <= o_chan_d;
            o_valid_q <= o_valid_d;
        end
    end

    assign bus.o_data  = o_data_q;
    assign bus.o_chan  = o_chan_q;
    assign bus.o_valid = o_valid_q;

endmodule

// File: tb/tb_mux_rr_reg.sv
// Bench for mux_rr_reg (NCH=4, WIDTH=5, SELW=3): hand-computed grant table, corner sequences,
// a random phase against a small reference model, and an in-order scoreboard of transferred words.
module tb_mux_rr_reg;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mux_rr_reg_if #(.WIDTH(5), .NCH(4), .SELW(3)) bus ();

    mux_rr_reg #(.WIDTH(5), .NCH(4), .SELW(3)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    typedef struct {
        logic       mode;
        logic [2:0] sel;
        logic [3:0] valid;
        logic       ready;
        logic [3:0] exp_rdy;
    } vec_t;

    vec_t       tbl [19];
    logic [4:0] chd [4];
    logic [7:0] sb_q [$];

    int         checks = 0;
    int         errors = 0;
    int         m_ptr  = 0;
    logic       m_valid = 1'b0;
    logic [4:0] m_data  = '0;
    logic [2:0] m_chan  = '0;

    function automatic logic [3:0] model_grant(input logic mode, input logic [2:0] sel,
                                               input logic [3:0] v, input int ptr,
                                               input logic ld, input logic r);
        logic [3:0] g;
        int s;
        int idx;
        g = '0;
        if (r || !ld) return g;
        if (!mode) begin
            s = int'(sel);
            if (s < 4 && v[s]) g[s] = 1'b1;
        end else begin
            for (int off = 0; off < 4; off++) begin
                idx = (ptr + off) % 4;
                if (v[idx]) begin
                    g[idx] = 1'b1;
                    return g;
                end
            end
        end
        return g;
    endfunction

    function automatic int onehot_idx(input logic [3:0] g);
        for (int k = 0; k < 4; k++) if (g[k]) return k;
        return 0;
    endfunction

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic step(input logic mode, input logic [2:0] sel, input logic [3:0] v,
                        input logic rdy, input logic r, input logic [3:0] exp_rdy,
                        input string tag);
        logic [3:0] mg;
        logic [7:0] ent;
        logic       ld;
        int         g;
        bus.i_mode  = mode;
        bus.i_sel   = sel;
        bus.i_valid = v;
        bus.i_ready = rdy;
        bus.i_data  = {chd[3], chd[2], chd[1], chd[0]};
        rst         = r;
        #1;
        check_val({tag, " o_ready"}, 32'(bus.o_ready), 32'(exp_rdy));
        check_val({tag, " o_valid"}, 32'(bus.o_valid), 32'(m_valid));
        check_val({tag, " o_data"},  32'(bus.o_data),  32'(m_data));
        check_val({tag, " o_chan"},  32'(bus.o_chan),  32'(m_chan));
        if (bus.o_valid && rdy && !r) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL %s scoreboard: got word %0h/%0h want none", tag, bus.o_chan, bus.o_data);
            end else begin
                ent = sb_q.pop_front();
                if ({bus.o_chan, bus.o_data} !== ent) begin
                    errors++;
                    $display("FAIL %s scoreboard: got %0h/%0h want %0h/%0h",
                             tag, bus.o_chan, bus.o_data, ent[7:5], ent[4:0]);
                end
            end
        end
        ld = !m_valid || rdy;
        mg = model_grant(mode, sel, v, m_ptr, ld, r);
        g  = onehot_idx(mg);
        if (mg != 0) sb_q.push_back({3'(g), chd[g]});
        $display("%s mode=%0d sel=%0d valid=%b ready=%b rst=%b o_ready=%b o_valid=%0d o_chan=%0d o_data=%h",
                 tag, mode, sel, v, rdy, r, bus.o_ready, bus.o_valid, bus.o_chan, bus.o_data);
        @(posedge clk);
        #1;
        if (r) begin
            m_valid = 1'b0;
            m_data  = '0;
            m_chan  = '0;
            m_ptr   = 0;
            sb_q.delete();
        end else if (ld) begin
            m_valid = (mg != 0);
            if (mg != 0) begin
                m_data = chd[g];
                m_chan = 3'(g);
                if (mode) m_ptr = (g + 1) % 4;
            end
        end
    endtask

    initial begin
        logic [3:0] v;
        logic [3:0] eg;
        logic       md;
        logic       rd;
        logic [2:0] sl;

        // Hand-derived expected grants, applied in order from reset (ptr=0, output empty).
        tbl[0]  = '{1'b0, 3'd2, 4'b0100, 1'b1, 4'b0100};
        tbl[1]  = '{1'b1, 3'd0, 4'b1111, 1'b1, 4'b0001};
        tbl[2]  = '{1'b1, 3'd0, 4'b1111, 1'b1, 4'b0010};
        tbl[3]  = '{1'b1, 3'd0, 4'b1111, 1'b1, 4'b0100};
        tbl[4]  = '{1'b1, 3'd0, 4'b1111, 1'b1, 4'b1000};
        tbl[5]  = '{1'b1, 3'd0, 4'b1111, 1'b1, 4'b0001};
        tbl[6]  = '{1'b1, 3'd0, 4'b1111, 1'b0, 4'b0000};
        tbl[7]  = '{1'b1, 3'd0, 4'b1111, 1'b0, 4'b0000};
        tbl[8]  = '{1'b1, 3'd0, 4'b1111, 1'b0, 4'b0000};
        tbl[9]  = '{1'b0, 3'd5, 4'b1111, 1'b1, 4'b0000};
        tbl[10] = '{1'b0, 3'd5, 4'b1111, 1'b1, 4'b0000};
        tbl[11] = '{1'b1, 3'd0, 4'b0000, 1'b1, 4'b0000};
        tbl[12] = '{1'b0, 3'd1, 4'b1101, 1'b1, 4'b0000};
        tbl[13] = '{1'b1, 3'd0, 4'b0001, 1'b1, 4'b0001};
        tbl[14] = '{1'b0, 3'd3, 4'b1000, 1'b0, 4'b0000};
        tbl[15] = '{1'b0, 3'd3, 4'b1000, 1'b1, 4'b1000};
        tbl[16] = '{1'b1, 3'd0, 4'b0100, 1'b1, 4'b0100};
        tbl[17] = '{1'b1, 3'd0, 4'b0010, 1'b1, 4'b0010};
        tbl[18] = '{1'b1, 3'd0, 4'b1111, 1'b1, 4'b0100};

        chd[0] = 5'h0A;
        chd[1] = 5'h11;
        chd[2] = 5'h15;
        chd[3] = 5'h1E;
        bus.i_mode  = 1'b0;
        bus.i_sel   = '0;
        bus.i_valid = '0;
        bus.i_ready = 1'b0;
        bus.i_data  = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        step(1'b1, 3'd0, 4'b1111, 1'b1, 1'b1, 4'b0000, "reset");

        for (int i = 0; i < 19; i++) begin
            step(tbl[i].mode, tbl[i].sel, tbl[i].valid, tbl[i].ready, 1'b0, tbl[i].exp_rdy,
                 $sformatf("vec%0d", i));
        end

        // Reset while a word is pending: word discarded, ptr back to 0.
        step(1'b1, 3'd0, 4'b1111, 1'b0, 1'b0, 4'b0000, "pre_rst");
        step(1'b1, 3'd0, 4'b1111, 1'b1, 1'b1, 4'b0000, "mid_rst");
        step(1'b1, 3'd0, 4'b1111, 1'b1, 1'b0, 4'b0001, "post_rst");
        step(1'b1, 3'd0, 4'b1111, 1'b1, 1'b0, 4'b0010, "post_rst2");

        for (int i = 0; i < 300; i++) begin
            for (int k = 0; k < 4; k++) chd[k] = 5'($urandom);
            md = 1'($urandom);
            sl = 3'($urandom_range(0, 7));
            v  = 4'($urandom);
            rd = ($urandom_range(0, 9) < 7);
            eg = model_grant(md, sl, v, m_ptr, !m_valid || rd, 1'b0);
            step(md, sl, v, rd, 1'b0, eg, $sformatf("rnd%0d", i));
        end

        repeat (2) step(1'b1, 3'd0, 4'b0000, 1'b1, 1'b0, 4'b0000, "drain");
        check_val("scoreboard empty", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_rr_reg.md
MUX_RR_REG -- requirements
Module: mux_rr_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 5, giving the data width per channel in bits.
REQ-002 The block SHALL have parameter NCH, default 4, giving the channel count; legal range is 2..16.
REQ-003 The block SHALL have parameter SELW, default 2, giving the select/index width; SELW SHALL be at least clog2(NCH).
REQ-004 i_clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 i_rst  input  1  reset, synchronous, active-high.
REQ-006 i_data  input  NCH*WIDTH  flattened channel data; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-007 i_valid  input  NCH  per-channel request; bit k means channel k data is valid.
REQ-008 o_ready  output  NCH  per-channel grant; channel k transfers on a cycle when i_valid[k] and o_ready[k] are both 1.
REQ-009 i_mode  input  1  0 selects fixed mode (channel chosen by i_sel); 1 selects round-robin mode.
REQ-010 i_sel  input  SELW  channel index used in fixed mode.
REQ-011 o_data  output  WIDTH  registered selected data.
REQ-012 o_chan  output  SELW  registered index of the channel that produced o_data.
REQ-013 o_valid  output  1  o_data and o_chan hold an untaken word.
REQ-014 i_ready  input  1  downstream accepts o_data on a cycle when o_valid and i_ready are both 1.

Function
REQ-015 load SHALL equal (!o_valid || i_ready), computed combinationally.
REQ-016 o_ready SHALL be combinational, at most one-hot, and all-zero whenever load=0 or i_rst=1.
REQ-017 In fixed mode, o_ready[i_sel] SHALL equal i_valid[i_sel] && load.
REQ-018 In fixed mode, when i_sel >= NCH, no grant SHALL be issued.
REQ-019 In round-robin mode, the grant SHALL go to the first channel with i_valid=1, searching from index ptr upward and wrapping from NCH-1 to 0; it SHALL be issued only when load=1.
REQ-020 On a round-robin grant to channel g, ptr SHALL become (g+1) mod NCH at the next edge.
REQ-021 ptr SHALL hold its value when there is no grant and in fixed mode.
REQ-022 On a transfer, o_data SHALL take the granted channel's data, o_chan SHALL take g, and o_valid SHALL become 1 at the next edge (1-cycle latency).
REQ-023 When load=1 and there is no grant, o_valid SHALL become 0; o_data and o_chan SHALL hold.
REQ-024 When load=0, o_data, o_chan and o_valid SHALL hold (stall), with no grants issued.
REQ-025 Simultaneous downstream take and new grant SHALL give back-to-back throughput of one word per cycle.
REQ-026 A change of i_mode or i_sel SHALL affect only the grant of the same cycle; no state SHALL be flushed.
REQ-027 A word taken is never lost or duplicated: each upstream handshake SHALL yield exactly one downstream handshake, in order.

Reset
REQ-028 While i_rst=1 at an edge: o_valid SHALL be 0, o_data 0, o_chan 0, ptr 0, and no transfer SHALL occur; reset overrides any in-flight word (mid-operation reset discards it).
REQ-029 The first grant after reset deassertion SHALL follow REQ-017/REQ-019 with ptr=0.

Verification
REQ-030 Fixed mode, i_sel=2, i_valid=4'b0100, i_data ch2=5'h15, i_ready=1 -> o_ready=4'b0100, and one cycle later o_data=5'h15, o_chan=2, o_valid=1.
REQ-031 Round-robin mode, i_valid=4'b1111 held, i_ready=1, for 5 cycles -> grants to channels 0,1,2,3,0 and o_chan follows the same sequence one cycle later.
REQ-032 Round-robin with ptr=3, i_valid=4'b0010 -> grant to channel 1 (wrap), then ptr=2.
REQ-033 o_valid=1 and i_ready=0 for 3 cycles with all channels valid -> o_ready=0 throughout, and o_data/o_chan stable.
REQ-034 Fixed mode with i_sel=5 (SELW=3, NCH=4) -> no grant; o_valid falls to 0 after the pending word is taken.
REQ-035 i_rst=1 asserted while o_valid=1 -> next cycle o_valid=0, o_data=0, o_chan=0, and the first round-robin grant after reset goes to channel 0 when all channels are valid.
